// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg: shared constants and types for the framebuffer port arbiter.
// Default geometry is an 800x600 display backed by a 200x150 RGB444 framebuffer.
package fb_arb_pkg;

  localparam int DISP_W = 800;
  localparam int DISP_H = 600;
  localparam int SCALE  = 2;
  localparam int PIXW   = 12;
  localparam int RD_LAT = 2;

  localparam int FB_W = DISP_W >> SCALE;
  localparam int FB_H = DISP_H >> SCALE;
  localparam int BUF_ADDR_W = 15;

  typedef logic [PIXW-1:0] pixel_t;
  typedef logic [BUF_ADDR_W-1:0] buf_addr_t;

  typedef enum logic {
    IDLE,
    PENDING
  } swap_state_t;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// fb_port_arbiter_if: renderer-side write handshake and buffer swap signals.
// The renderer drives through master; the arbiter answers through slave.
interface fb_port_arbiter_if;
  import fb_arb_pkg::*;

  logic      wr_valid_in;
  logic      wr_ready_out;
  buf_addr_t wr_addr_in;
  pixel_t    wr_data_in;
  logic      swap_req_in;
  logic      swap_busy_out;
  logic      swap_ack_out;

  modport master (
    output wr_valid_in, wr_addr_in, wr_data_in, swap_req_in,
    input  wr_ready_out, swap_busy_out, swap_ack_out
  );

  modport slave (
    input  wr_valid_in, wr_addr_in, wr_data_in, swap_req_in,
    output wr_ready_out, swap_busy_out, swap_ack_out
  );

endinterface

// File: rtl/fb_read_pipe.sv
// fb_read_pipe: tracks scanout fetches through the BRAM latency and
// captures returning read data into the held pixel register.
module fb_read_pipe #(
  parameter int DEPTH = 3,
  parameter int PIX_W = 12
) (
  input  logic             pixel_clk_in,
  input  logic             rst_in,
  input  logic             slot_in,
  input  logic [PIX_W-1:0] rdata_in,
  output logic [PIX_W-1:0] pixel_out,
  output logic             pixel_valid_out
);

  logic [DEPTH-1:0] vld;

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      vld             <= '0;
      pixel_out       <= '0;
      pixel_valid_out <= 1'b0;
    end else begin
      vld             <= DEPTH'({vld, slot_in});
      pixel_valid_out <= vld[DEPTH-1];
      if (vld[DEPTH-1]) pixel_out <= rdata_in;
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one single-port framebuffer BRAM between scanout and renderer.
// Define ARB_STATS_EN to add stall_cnt_out and frame_cnt_out statistics ports.
module fb_port_arbiter
  import fb_arb_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = DISP_W,
  parameter int DISPLAY_HEIGHT = DISP_H,
  parameter int SCALE_SHIFT    = SCALE,
  parameter int PIX_W          = PIXW,
  parameter int RD_LATENCY     = RD_LAT
) (
  input  logic             pixel_clk_in,
  input  logic             rst_in,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  fb_port_arbiter_if.slave wr,
  output logic [15:0]      fb_addr_out,
  output logic             fb_we_out,
  output logic [PIX_W-1:0] fb_wdata_out,
  input  logic [PIX_W-1:0] fb_rdata_in,
  output logic [PIX_W-1:0] pixel_out,
`ifdef ARB_STATS_EN
  output logic [31:0]      stall_cnt_out,
  output logic [15:0]      frame_cnt_out,
`endif
  output logic             pixel_valid_out
);

  localparam int FbW = DISPLAY_WIDTH >> SCALE_SHIFT;
  localparam int FbH = DISPLAY_HEIGHT >> SCALE_SHIFT;
  localparam buf_addr_t  FbWc   = buf_addr_t'(FbW);
  localparam buf_addr_t  FbSize = buf_addr_t'(FbW * FbH);
  localparam logic [10:0] HEnd  = 11'(DISPLAY_WIDTH);
  localparam logic [9:0]  VEnd  = 10'(DISPLAY_HEIGHT);
  localparam logic [10:0] HMask = 11'((1 << SCALE_SHIFT) - 1);

  swap_state_t state;
  logic        front;
  logic        swap_ack;
  logic        slot;
  logic        vblank_start;
  logic        wr_fire;
  buf_addr_t   rd_addr;

  assign slot = (hcount_in < HEnd) && (vcount_in < VEnd)
             && ((hcount_in & HMask) == '0);
  assign vblank_start = (hcount_in == '0) && (vcount_in == VEnd);

  assign rd_addr = buf_addr_t'(vcount_in >> SCALE_SHIFT) * FbWc
                 + buf_addr_t'(hcount_in >> SCALE_SHIFT);

  assign wr.wr_ready_out  = ~slot & (state == IDLE);
  assign wr.swap_busy_out = (state == PENDING);
  assign wr.swap_ack_out  = swap_ack;
  assign wr_fire = wr.wr_valid_in & wr.wr_ready_out;

  // Front only flips at vblank start so scanout never sees a half frame.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      front    <= 1'b0;
      swap_ack <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr.swap_req_in) state <= PENDING;
        end
        PENDING: begin
          if (vblank_start) begin
            state    <= IDLE;
            front    <= ~front;
            swap_ack <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      fb_addr_out  <= '0;
      fb_we_out    <= 1'b0;
      fb_wdata_out <= '0;
    end else begin
      fb_we_out <= 1'b0;
      unique case (1'b1)
        slot: fb_addr_out <= {front, rd_addr};
        wr_fire && (wr.wr_addr_in < FbSize): begin
          fb_addr_out  <= {~front, wr.wr_addr_in};
          fb_we_out    <= 1'b1;
          fb_wdata_out <= wr.wr_data_in;
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      stall_cnt_out <= '0;
      frame_cnt_out <= '0;
    end else begin
      if (wr.wr_valid_in && !wr.wr_ready_out)
        stall_cnt_out <= stall_cnt_out + 32'd1;
      if (state == PENDING && vblank_start)
        frame_cnt_out <= frame_cnt_out + 16'd1;
    end
  end
`endif

  fb_read_pipe #(
    .DEPTH (RD_LATENCY + 1),
    .PIX_W (PIX_W)
  ) u_read_pipe (
    .pixel_clk_in    (pixel_clk_in),
    .rst_in          (rst_in),
    .slot_in         (slot),
    .rdata_in        (fb_rdata_in),
    .pixel_out       (pixel_out),
    .pixel_valid_out (pixel_valid_out)
  );

endmodule
